// File: rtl/comp_search.sv
// ============================================================================
// Module   : comp_search
// Purpose  : Binary-search controller for a magnitude comparator. It drives the
//            comparator's B operand with successive guesses, reads back the
//            three flags, and recovers the unknown A operand in at most
//            WIDTH+1 probes. Flags that are not one-hot, or that contradict the
//            search range, end the search with an error.
// Ports    :
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active-high
//   iStart   in   begin a search (ignored while searching)
//   iAgtB    in   comparator flag: A > guess
//   iAltB    in   comparator flag: A < guess
//   iAeqB    in   comparator flag: A == guess
//   oGuess   out  value driven to the comparator B operand (registered)
//   oBusy    out  high while searching
//   oDone    out  high from search completion until next start or reset
//   oFound   out  valid with oDone; oResult holds the recovered value
//   oErr     out  valid with oDone; inconsistent flags were seen
//   oResult  out  recovered A value
//   oProbes  out  comparisons performed in the last/current search
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module comp_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iStart,
  input  logic             iAgtB,
  input  logic             iAltB,
  input  logic             iAeqB,
  output logic [WIDTH-1:0] oGuess,
  output logic             oBusy,
  output logic             oDone,
  output logic             oFound,
  output logic             oErr,
  output logic [WIDTH-1:0] oResult,
  output logic [WIDTH-1:0] oProbes
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_VAL     = '1;
  localparam logic [WIDTH-1:0] PROBE_LIMIT = WIDTH'(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lo, lo_nxt;
  logic [WIDTH-1:0] hi, hi_nxt;
  logic [WIDTH-1:0] guess_nxt;
  logic             busy_nxt, done_nxt, found_nxt, err_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic [WIDTH-1:0] probes_nxt;
  logic [WIDTH-1:0] probes_inc;
  logic [2:0]       flags;

  // Midpoint of lo..hi; the sum carries one extra bit so it never wraps.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return WIDTH'(sum >> 1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lo      <= '0;
      hi      <= MAX_VAL;
      oGuess  <= '0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oFound  <= 1'b0;
      oErr    <= 1'b0;
      oResult <= '0;
      oProbes <= '0;
    end else begin
      state   <= state_nxt;
      lo      <= lo_nxt;
      hi      <= hi_nxt;
      oGuess  <= guess_nxt;
      oBusy   <= busy_nxt;
      oDone   <= done_nxt;
      oFound  <= found_nxt;
      oErr    <= err_nxt;
      oResult <= result_nxt;
      oProbes <= probes_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    lo_nxt     = lo;
    hi_nxt     = hi;
    guess_nxt  = oGuess;
    busy_nxt   = oBusy;
    done_nxt   = oDone;
    found_nxt  = oFound;
    err_nxt    = oErr;
    result_nxt = oResult;
    probes_nxt = oProbes;
    probes_inc = oProbes + ONE;
    flags      = {iAgtB, iAltB, iAeqB};

    case (state)
      IDLE, DONE: begin
        if (iStart) begin
          lo_nxt     = '0;
          hi_nxt     = MAX_VAL;
          guess_nxt  = midpoint('0, MAX_VAL);
          probes_nxt = '0;
          done_nxt   = 1'b0;
          found_nxt  = 1'b0;
          err_nxt    = 1'b0;
          busy_nxt   = 1'b1;
          state_nxt  = CMP;
        end
      end

      CMP: begin
        probes_nxt = probes_inc;
        // Every non-continuing branch lands in DONE; the CMP branches below
        // override the state only when the search keeps going.
        state_nxt  = DONE;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b1;
        if (flags == 3'b001) begin
          result_nxt = oGuess;
          found_nxt  = 1'b1;
        end else if (probes_inc == PROBE_LIMIT) begin
          // An honest comparator is always matched within WIDTH+1 probes,
          // so reaching the limit means the flags were lying. The guess is
          // left on the last probed value.
          err_nxt = 1'b1;
        end else if (flags == 3'b100) begin
          if (oGuess == MAX_VAL) begin
            err_nxt = 1'b1;
          end else begin
            lo_nxt    = oGuess + ONE;
            guess_nxt = midpoint(oGuess + ONE, hi);
            state_nxt = CMP;
            busy_nxt  = 1'b1;
            done_nxt  = 1'b0;
          end
        end else if (flags == 3'b010) begin
          if (oGuess == '0) begin
            err_nxt = 1'b1;
          end else begin
            hi_nxt    = oGuess - ONE;
            guess_nxt = midpoint(lo, oGuess - ONE);
            state_nxt = CMP;
            busy_nxt  = 1'b1;
            done_nxt  = 1'b0;
          end
        end else begin
          // 000 or multi-hot flags
          err_nxt   = 1'b1;
          found_nxt = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_comp_search.sv
// ============================================================================
// Module   : tb_comp_search
// Purpose  : Self-checking bench for comp_search. A behavioural model walks an
//            integer lo/hi range per probe and records the expected guess
//            sequence and final status; the bench plays the comparator (or a
//            faulty one) and compares the DUT against that model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comp_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       iStart, iAgtB, iAltB, iAeqB;
  logic [3:0] oGuess, oResult, oProbes;
  logic       oBusy, oDone, oFound, oErr;

  int n_tests = 0;
  int n_fail  = 0;

  // Model results
  int exp_g[$];
  bit exp_found, exp_err;
  int exp_res, exp_probes;
  int lie_q[6];

  comp_search #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .iStart(iStart),
    .iAgtB(iAgtB), .iAltB(iAltB), .iAeqB(iAeqB),
    .oGuess(oGuess), .oBusy(oBusy), .oDone(oDone), .oFound(oFound),
    .oErr(oErr), .oResult(oResult), .oProbes(oProbes)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Comparator behaviour per mode, as {gt, lt, eq}.
  // 0 honest, 1 all-zero, 2 always lt, 3 always gt, 4 gt+lt, 5 scripted lies
  function automatic logic [2:0] flags_for(int mode, int a, int g, int k);
    case (mode)
      0:       return (a > g) ? 3'b100 : (a < g) ? 3'b010 : 3'b001;
      1:       return 3'b000;
      2:       return 3'b010;
      3:       return 3'b100;
      4:       return 3'b110;
      default: return 3'(lie_q[k]);
    endcase
  endfunction

  task automatic model(input int mode, input int a);
    int lo, hi, g, n;
    logic [2:0] f;
    lo = 0; hi = 15; g = (lo + hi) / 2; n = 0;
    exp_g.delete();
    exp_found = 0; exp_err = 0; exp_res = 0;
    forever begin
      exp_g.push_back(g);
      f = flags_for(mode, a, g, n);
      n++;
      if (f == 3'b001) begin exp_found = 1; exp_res = g; break; end
      if (n == 5) begin exp_err = 1; break; end
      if (f == 3'b100) begin
        if (g == 15) begin exp_err = 1; break; end
        lo = g + 1; g = (lo + hi) / 2;
      end else if (f == 3'b010) begin
        if (g == 0) begin exp_err = 1; break; end
        hi = g - 1; g = (lo + hi) / 2;
      end else begin
        exp_err = 1; break;
      end
    end
    exp_probes = n;
  endtask

  task automatic run_search(input int mode, input int a, input bit noisy);
    logic [2:0] f;
    model(mode, a);
    @(negedge clk);
    iStart = 1'b1;
    for (int k = 0; k < exp_g.size(); k++) begin
      @(negedge clk);
      if (k == 0) iStart = 1'b0;
      else if (noisy) iStart = 1'($urandom_range(0, 1));
      check($sformatf("guess m%0d a%0d p%0d", mode, a, k), 32'(oGuess), 32'(exp_g[k]));
      check("busy", 32'(oBusy), 32'd1);
      f = flags_for(mode, a, int'(oGuess), k);
      {iAgtB, iAltB, iAeqB} = f;
    end
    @(negedge clk);
    iStart = 1'b0;
    check($sformatf("done m%0d a%0d", mode, a), 32'(oDone), 32'd1);
    check("busy_end", 32'(oBusy), 32'd0);
    check($sformatf("found m%0d a%0d", mode, a), 32'(oFound), 32'(exp_found));
    check($sformatf("err m%0d a%0d", mode, a), 32'(oErr), 32'(exp_err));
    check($sformatf("probes m%0d a%0d", mode, a), 32'(oProbes), 32'(exp_probes));
    check("guess_hold", 32'(oGuess), 32'(exp_g[exp_g.size()-1]));
    if (exp_found) check($sformatf("result a%0d", a), 32'(oResult), 32'(exp_res));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " guess"},  32'(oGuess),  32'd0);
    check({tag, " busy"},   32'(oBusy),   32'd0);
    check({tag, " done"},   32'(oDone),   32'd0);
    check({tag, " found"},  32'(oFound),  32'd0);
    check({tag, " err"},    32'(oErr),    32'd0);
    check({tag, " result"}, 32'(oResult), 32'd0);
    check({tag, " probes"}, 32'(oProbes), 32'd0);
  endtask

  initial begin
    rst = 1'b1; iStart = 1'b0; iAgtB = 1'b0; iAltB = 1'b0; iAeqB = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed searches
    run_search(0, 13, 0);
    run_search(0, 0, 0);
    run_search(0, 15, 0);

    // Exhaustive back-to-back from DONE
    for (int a = 0; a < 16; a++) run_search(0, a, 0);

    // Faulty comparators
    run_search(1, 5, 0);
    run_search(2, 5, 0);
    run_search(3, 5, 0);
    run_search(4, 5, 0);

    // Random honest searches with iStart toggling during CMP
    for (int r = 0; r < 20; r++) run_search(0, int'($urandom_range(0, 15)), 1);

    // Random lying comparator
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 6; k++)
        lie_q[k] = ($urandom_range(0, 3) != 0) ? (($urandom_range(0, 1) != 0) ? 4 : 2)
                                                : int'($urandom_range(0, 7));
      run_search(5, 0, 0);
    end

    // Reset during the second CMP cycle
    model(0, 9);
    @(negedge clk);
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    {iAgtB, iAltB, iAeqB} = flags_for(0, 9, int'(oGuess), 0);
    @(negedge clk);
    check("pre_rst guess", 32'(oGuess), 32'(exp_g[1]));
    rst = 1'b1;
    #1 check_all_zero("mid_rst");
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle busy", 32'(oBusy), 32'd0);
    check("idle done", 32'(oDone), 32'd0);
    check("idle guess", 32'(oGuess), 32'd0);
    run_search(0, 9, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
